sorted_triple_serializer: RTL and testbench

- Consumer end of the 3-input ascending sorter output.
- Captures a parallel sorted triple (F1 <= F2 <= F3) through a valid/ready handshake and buffers up to DEPTH triples.
- Emits each triple as three serial beats, smallest first, on a valid/ready stream with beat index and last flag.
- Optionally checks that every accepted triple is ascending and raises a sticky error if it is not.

---
 rtl/sorted_triple_serializer.sv | 160 ++++++++++++++++
 tb/tb_sorted_triple_serializer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_triple_serializer.sv
// Buffers sorted triples and emits each one as three serial beats, smallest first.
// Define ORDER_CHECK_EN to build the sticky out-of-order detector on accepted triples.
module sorted_triple_serializer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_f1,
  input  logic [DATA_W-1:0] in_f2,
  input  logic [DATA_W-1:0] in_f3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic              order_err,
  output logic [CNT_W-1:0]  triple_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 3 * DATA_W;

  typedef enum logic [1:0] {
    StEmpty,
    StBeat0,
    StBeat1,
    StBeat2
  } state_e;

  state_e state_q, state_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    occ, occ_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             push, pop, beat_hs;
  logic [EW-1:0]    head;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign full     = (occ == PW'(DEPTH));
  assign in_ready = ~full;

  assign push    = in_valid & in_ready;
  assign beat_hs = out_valid & out_ready;
  assign pop     = beat_hs & (state_q == StBeat2);

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign occ_next = wr_ptr_d - rd_ptr_d;
  assign cnt_d    = cnt_q + CNT_W'(pop);

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // Storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_f1, in_f2, in_f3};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Looking at next occupancy lets a fresh push reach BEAT0 in the very next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (occ_next != '0) state_d = StBeat0;
      end
      StBeat0: begin
        if (beat_hs) state_d = StBeat1;
      end
      StBeat1: begin
        if (beat_hs) state_d = StBeat2;
      end
      StBeat2: begin
        if (beat_hs) state_d = (occ_next != '0) ? StBeat0 : StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_idx   = 2'd0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state_q)
      StEmpty: begin
        out_valid = 1'b0;
      end
      StBeat0: begin
        out_valid = 1'b1;
        out_idx   = 2'd0;
        out_data  = head[EW-1 -: DATA_W];
      end
      StBeat1: begin
        out_valid = 1'b1;
        out_idx   = 2'd1;
        out_data  = head[2*DATA_W-1 -: DATA_W];
      end
      StBeat2: begin
        out_valid = 1'b1;
        out_idx   = 2'd2;
        out_last  = 1'b1;
        out_data  = head[DATA_W-1:0];
      end
      default: out_valid = 1'b0;
    endcase
  end

  assign triple_cnt = cnt_q;

`ifdef ORDER_CHECK_EN
  logic err_q;
  logic bad_order;

  assign bad_order = (in_f1 > in_f2) | (in_f2 > in_f3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (push && bad_order) begin
      err_q <= 1'b1;
    end
  end

  assign order_err = err_q;
`else
  assign order_err = 1'b0;
`endif

  // A stalled beat must not change, and the buffer can never hold more than DEPTH triples.
  stall_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_idx));

  occ_bound_a : assert property (@(posedge clk) disable iff (!rst_n)
    occ <= PW'(DEPTH));

endmodule

// File: tb/tb_sorted_triple_serializer.sv
// Randomised and directed bench for sorted_triple_serializer against a queue-based beat model.
module tb_sorted_triple_serializer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 4;

  logic              clk, rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_f1, in_f2, in_f3;
  logic              out_valid, out_ready, out_last, order_err;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_idx;
  logic [CNT_W-1:0]  triple_cnt;

  int checks = 0;
  int errors = 0;

  // Model: queue of buffered triples (head includes the one being emitted), beat index, totals.
  logic [3*DATA_W-1:0] mq[$];
  int                  mb;
  int                  total;
  bit                  exp_err;

  sorted_triple_serializer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_f1     (in_f1),
    .in_f2     (in_f2),
    .in_f3     (in_f3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .order_err (order_err),
    .triple_cnt(triple_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit exp_ready();
    return mq.size() < DEPTH;
  endfunction

  function automatic bit exp_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data();
    logic [3*DATA_W-1:0] h;
    if (mq.size() == 0) return '0;
    h = mq[0];
    return h[(2 - mb) * DATA_W +: DATA_W];
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
    return CNT_W'(total);
  endfunction

  task automatic model_reset();
    mq.delete();
    mb      = 0;
    total   = 0;
    exp_err = 1'b0;
  endtask

  task automatic drive(input int a, input int b, input int c);
    in_f1    = DATA_W'(a);
    in_f2    = DATA_W'(b);
    in_f3    = DATA_W'(c);
    in_valid = 1'b1;
  endtask

  // Advance one clock; inputs are set and outputs sampled around the falling edge.
  task automatic tick();
    bit                  ai, ao;
    logic [3*DATA_W-1:0] t;
    ai = in_valid && exp_ready();
    ao = out_ready && exp_valid();
    t  = {in_f1, in_f2, in_f3};
    @(posedge clk);
    if (ao) begin
      if (mb == 2) begin
        void'(mq.pop_front());
        mb = 0;
        total++;
      end else begin
        mb++;
      end
    end
    if (ai) begin
      mq.push_back(t);
`ifdef ORDER_CHECK_EN
      if (t[3*DATA_W-1 -: DATA_W] > t[2*DATA_W-1 -: DATA_W] ||
          t[2*DATA_W-1 -: DATA_W] > t[DATA_W-1:0]) exp_err = 1'b1;
`endif
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_f1 = '0; in_f2 = '0; in_f3 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if (triple_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", triple_cnt); end
    checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", order_err); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(3, 7, 9);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: valid %b want 1", out_valid); end
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (out_data !== exp_data() || out_idx !== 2'(mb) || out_last !== (mb == 2)) begin
        errors++;
        $display("FAIL single_beat%0d: data %0d idx %0d last %b want %0d %0d %b",
                 b, out_data, out_idx, out_last, exp_data(), mb, (mb == 2));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle: valid %b want 0", out_valid); end
    checks++; if (triple_cnt !== exp_cnt()) begin errors++; $display("FAIL single_cnt: got %0d want %0d", triple_cnt, exp_cnt()); end
    checks++; if (order_err !== exp_err) begin errors++; $display("FAIL single_err: got %b want %b", order_err, exp_err); end
  endtask

  task automatic test_back_to_back();
    int beats = 0;
    bit acc;
    out_ready = 1'b0;
    drive(1, 2, 3); tick();
    drive(4, 5, 6); tick();
    checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL b2b_full: ready %b want %b", in_ready, exp_ready()); end
    drive(7, 8, 9); tick();
    checks++;
    if (in_ready !== exp_ready() || out_data !== exp_data() || out_idx !== 2'(mb)) begin
      errors++;
      $display("FAIL b2b_hold: ready %b data %0d idx %0d want %b %0d %0d",
               in_ready, out_data, out_idx, exp_ready(), exp_data(), mb);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (exp_valid() || in_valid); c++) begin
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL b2b_ready c%0d: got %b want %b", c, in_ready, exp_ready()); end
      if (exp_valid()) begin
        beats++;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data()) begin
          errors++;
          $display("FAIL b2b_beat c%0d: valid %b data %0d want 1 %0d", c, out_valid, out_data, exp_data());
        end
      end
      acc = in_valid && exp_ready();
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++; if (beats != 9) begin errors++; $display("FAIL b2b_beats: got %0d want 9", beats); end
    checks++; if (triple_cnt !== exp_cnt()) begin errors++; $display("FAIL b2b_cnt: got %0d want %0d", triple_cnt, exp_cnt()); end
  endtask

  task automatic test_stall();
    bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b0;
    drive(10, 20, 30);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_ready = pat[i];
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data() || out_idx !== 2'(mb)) begin
        errors++;
        $display("FAIL stall_c%0d: valid %b data %0d idx %0d want 1 %0d %0d",
                 i, out_valid, out_data, out_idx, exp_data(), mb);
      end
      tick();
    end
    checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL stall_done: valid %b want %b", out_valid, exp_valid()); end
  endtask

  task automatic test_order();
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) drive(5, 4, 6); else drive(1, 1, 1);
      tick();
      in_valid = 1'b0;
      checks++; if (order_err !== exp_err) begin errors++; $display("FAIL order_err%0d: got %b want %b", t, order_err, exp_err); end
      for (int b = 0; b < 3; b++) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data()) begin
          errors++;
          $display("FAIL order_beat%0d_%0d: valid %b data %0d want 1 %0d", t, b, out_valid, out_data, exp_data());
        end
        tick();
      end
    end
    checks++; if (order_err !== exp_err) begin errors++; $display("FAIL order_sticky: got %b want %b", order_err, exp_err); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(8, 9, 10); tick();
    drive(11, 12, 13); tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_idx !== 2'(mb) || out_data !== exp_data()) begin errors++; $display("FAIL mid_pre: idx %0d data %0d want %0d %0d", out_idx, out_data, mb, exp_data()); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 2'd0 || out_last !== 1'b0 || triple_cnt !== '0 || order_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: valid %b idx %0d last %b cnt %0d err %b want 0 0 0 0 0",
               out_valid, out_idx, out_last, triple_cnt, order_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost%0d: valid %b want 0", i, out_valid); end
      tick();
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", in_ready); end
    drive(2, 3, 4); tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_data() || out_idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_first: valid %b data %0d idx %0d want 1 %0d 0", out_valid, out_data, out_idx, exp_data());
    end
    repeat (3) tick();
  endtask

  task automatic test_random();
    int a, b, c, s;
    bit acc;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        a = $urandom_range(0, 255);
        b = ($urandom_range(0, 4) == 0) ? a : $urandom_range(0, 255);
        c = $urandom_range(0, 255);
        if (a > b) begin s = a; a = b; b = s; end
        if (b > c) begin s = b; b = c; c = s; end
        if (a > b) begin s = a; a = b; b = s; end
        drive(a, b, c);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      checks++;
      if (in_ready !== exp_ready() || out_valid !== exp_valid() || triple_cnt !== exp_cnt() ||
          order_err !== exp_err) begin
        errors++;
        $display("FAIL rand_ctrl c%0d: ready %b valid %b cnt %0d err %b want %b %b %0d %b",
                 cyc, in_ready, out_valid, triple_cnt, order_err,
                 exp_ready(), exp_valid(), exp_cnt(), exp_err);
      end
      if (exp_valid()) begin
        checks++;
        if (out_data !== exp_data() || out_idx !== 2'(mb) || out_last !== (mb == 2)) begin
          errors++;
          $display("FAIL rand_beat c%0d: data %0d idx %0d last %b want %0d %0d %b",
                   cyc, out_data, out_idx, out_last, exp_data(), mb, (mb == 2));
        end
      end
      acc = in_valid && exp_ready();
      tick();
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12 && exp_valid(); i++) tick();
    checks++; if (out_valid !== 1'b0 || triple_cnt !== exp_cnt()) begin errors++; $display("FAIL rand_drain: valid %b cnt %0d want 0 %0d", out_valid, triple_cnt, exp_cnt()); end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int cyc    = 0;
    bit acc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    while (total < 17 && cyc < 200) begin
      if (pushed < 17) drive(pushed, pushed + 1, pushed + 2);
      else in_valid = 1'b0;
      acc = in_valid && exp_ready();
      tick();
      if (acc) pushed++;
      cyc++;
    end
    checks++; if (total != 17) begin errors++; $display("FAIL wrap_timeout: emitted %0d want 17", total); end
    checks++; if (triple_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d want 1", triple_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_order();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
